hmmm_io_unit: RTL and testbench

Parametrised I/O and program-load controller for the ConfusedCore HMMM processor. It replaces the core's single-word `inputReady`/`inputWaiting` exchange with three pieces:
- a buffered input FIFO;
- a registered output port with a strobe;
- a flash-load mode that streams words from the input port into instruction ROM.

It sits between the core datapath (read/write instruction handshake, stall) and the off-chip peripheral / ROM write port.

---
 rtl/hmmm_io_pkg.sv | 16 +
 rtl/hmmm_io_unit_fifo.sv | 59 +++++
 rtl/hmmm_io_unit.sv | 166 ++++++++++++++++
 tb/tb_hmmm_io_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_io_pkg.sv
// hmmm_io_pkg: shared types and default sizes for the HMMM I/O unit.
//   io_state_t : controller state (idle, blocked on input, program load)
//   Def*       : default data width, input FIFO depth and ROM address width
package hmmm_io_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefRomAw = 8;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_WAIT_IN,
    IO_FLASH
  } io_state_t;

endpackage

// File: rtl/hmmm_io_unit_fifo.sv
// io_fifo: synchronous WIDTH x DEPTH FIFO with show-ahead read data.
//   clk, reset    : clock, synchronous active-high reset
//   push, wdata   : write request and data (ignored when full)
//   pop           : read request (ignored when empty); rdata is the current head
//   flush         : drop all entries (wins over push/pop)
//   full, empty   : occupancy flags
//   count         : number of entries held
module io_fifo
  import hmmm_io_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PtrW:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/hmmm_io_unit.sv
// hmmm_io_unit: buffered input, registered output and flash-load controller for the HMMM core.
//   inputReady/inputAccept/parallelIn : peripheral input handshake
//   inputWaiting, ioBusy              : core blocked on input / core must stall
//   readReq -> readData/readValid     : core read, result one cycle later
//   writeReq/writeData -> parallelOut/outValid : core write, registered output
//   flashEnable -> romWe/romAddr/romWd, flashDone, flashFull : program load into ROM
module hmmm_io_unit
  import hmmm_io_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ROM_AW = DefRomAw
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inputReady,
  output logic              inputAccept,
  input  logic [WIDTH-1:0]  parallelIn,
  output logic              inputWaiting,
  output logic [WIDTH-1:0]  parallelOut,
  output logic              outValid,
  input  logic              readReq,
  output logic [WIDTH-1:0]  readData,
  output logic              readValid,
  input  logic              writeReq,
  input  logic [WIDTH-1:0]  writeData,
  output logic              ioBusy,
  input  logic              flashEnable,
  output logic              romWe,
  output logic [ROM_AW-1:0] romAddr,
  output logic [WIDTH-1:0]  romWd,
  output logic              flashDone,
  output logic              flashFull
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  io_state_t state_q, state_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [WIDTH-1:0]  fifo_rdata;
  logic [PtrW:0]     fifo_count;
  logic              bypass, flash_wr, flash_exit;

  logic [WIDTH-1:0]  read_data_q, parallel_out_q, rom_wd_q;
  logic [ROM_AW-1:0] rom_addr_q, addr_cnt_q;
  logic              read_valid_q, out_valid_q, rom_we_q, flash_done_q, flash_full_q;

  io_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .wdata(parallelIn),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IO_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IO_IDLE: begin
        if (readReq && fifo_empty)           state_d = IO_WAIT_IN;
        else if (flashEnable && !readReq)    state_d = IO_FLASH;
      end
      IO_WAIT_IN: if (!fifo_empty || inputReady) state_d = IO_IDLE;
      IO_FLASH:   if (!flashEnable)              state_d = IO_IDLE;
      default:    state_d = IO_IDLE;
    endcase
  end

  always_comb begin
    inputAccept  = 1'b0;
    inputWaiting = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    bypass       = 1'b0;
    flash_wr     = 1'b0;
    unique case (state_q)
      IO_IDLE: begin
        inputAccept = !fifo_full;
        fifo_push   = inputReady && !fifo_full;
        fifo_pop    = readReq && !fifo_empty;
        fifo_flush  = flashEnable && !readReq;
      end
      IO_WAIT_IN: begin
        inputWaiting = 1'b1;
        inputAccept  = 1'b1;
        // A word pushed in the same cycle the miss was taken sits in the FIFO;
        // serve it first and queue any new word behind it.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          fifo_push = inputReady;
        end else begin
          bypass = inputReady;
        end
      end
      IO_FLASH: begin
        inputAccept = !flash_full_q;
        flash_wr    = inputReady && !flash_full_q;
      end
      default: ;
    endcase
    ioBusy = (readReq && fifo_count == '0) || (state_q != IO_IDLE);
  end

  assign flash_exit = (state_q == IO_FLASH) && !flashEnable;

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      parallel_out_q <= '0;
      out_valid_q    <= 1'b0;
      rom_we_q       <= 1'b0;
      rom_addr_q     <= '0;
      rom_wd_q       <= '0;
      addr_cnt_q     <= '0;
      flash_done_q   <= 1'b0;
      flash_full_q   <= 1'b0;
    end else begin
      read_valid_q <= fifo_pop || bypass;
      if (fifo_pop)    read_data_q <= fifo_rdata;
      else if (bypass) read_data_q <= parallelIn;

      out_valid_q <= writeReq && (state_q != IO_FLASH);
      if (writeReq && (state_q != IO_FLASH)) parallel_out_q <= writeData;

      rom_we_q <= flash_wr;
      if (flash_wr) begin
        rom_addr_q <= addr_cnt_q;
        rom_wd_q   <= parallelIn;
        // Saturate at the top address instead of wrapping.
        if (addr_cnt_q == {ROM_AW{1'b1}}) flash_full_q <= 1'b1;
        else                              addr_cnt_q   <= addr_cnt_q + 1'b1;
      end
      if (fifo_flush) addr_cnt_q <= '0;

      flash_done_q <= flash_exit;
      if (flash_exit) flash_full_q <= 1'b0;
    end
  end

  assign readData    = read_data_q;
  assign readValid   = read_valid_q;
  assign parallelOut = parallel_out_q;
  assign outValid    = out_valid_q;
  assign romWe       = rom_we_q;
  assign romAddr     = rom_addr_q;
  assign romWd       = rom_wd_q;
  assign flashDone   = flash_done_q;
  assign flashFull   = flash_full_q;

endmodule

// File: tb/tb_hmmm_io_unit.sv
module tb_hmmm_io_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inputReady = 1'b0;
  logic        inputAccept;
  logic [15:0] parallelIn = '0;
  logic        inputWaiting;
  logic [15:0] parallelOut;
  logic        outValid;
  logic        readReq = 1'b0;
  logic [15:0] readData;
  logic        readValid;
  logic        writeReq = 1'b0;
  logic [15:0] writeData = '0;
  logic        ioBusy;
  logic        flashEnable = 1'b0;
  logic        romWe;
  logic [1:0]  romAddr;
  logic [15:0] romWd;
  logic        flashDone;
  logic        flashFull;

  int checks = 0;
  int errors = 0;

  hmmm_io_unit #(
    .WIDTH (16),
    .DEPTH (4),
    .ROM_AW(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inputReady  (inputReady),
    .inputAccept (inputAccept),
    .parallelIn  (parallelIn),
    .inputWaiting(inputWaiting),
    .parallelOut (parallelOut),
    .outValid    (outValid),
    .readReq     (readReq),
    .readData    (readData),
    .readValid   (readValid),
    .writeReq    (writeReq),
    .writeData   (writeData),
    .ioBusy      (ioBusy),
    .flashEnable (flashEnable),
    .romWe       (romWe),
    .romAddr     (romAddr),
    .romWd       (romWd),
    .flashDone   (flashDone),
    .flashFull   (flashFull)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (inputAccept !== 1'b1) begin errors++; $display("FAIL reset_accept got %b want 1", inputAccept); end
    checks++; if ({readValid, outValid, romWe, flashDone, flashFull, inputWaiting, ioBusy} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000000", {readValid, outValid, romWe, flashDone, flashFull, inputWaiting, ioBusy});
    end
    checks++; if ({readData, parallelOut, romWd} !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", {readData, parallelOut, romWd}); end
    checks++; if (romAddr !== 2'd0) begin errors++; $display("FAIL reset_romaddr got %h want 0", romAddr); end
  endtask

  task automatic test_buffered;
    logic [15:0] words [3];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      inputReady = 1'b1; parallelIn = words[i];
      step();
    end
    inputReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      readReq = 1'b1;
      checks++; if (ioBusy !== 1'b0) begin errors++; $display("FAIL buf_busy%0d got %b want 0", i, ioBusy); end
      step();
      readReq = 1'b0;
      checks++; if (readValid !== 1'b1 || readData !== words[i]) begin
        errors++; $display("FAIL buf_read%0d got v=%b d=%h want v=1 d=%h", i, readValid, readData, words[i]);
      end
    end
    step();
    checks++; if (readValid !== 1'b0) begin errors++; $display("FAIL buf_strobe got %b want 0", readValid); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) begin
      inputReady = 1'b1; parallelIn = 16'hA000 + 16'(i);
      step();
    end
    parallelIn = 16'hBEEF;
    checks++; if (inputAccept !== 1'b0) begin errors++; $display("FAIL full_accept got %b want 0", inputAccept); end
    step();
    inputReady = 1'b0;
    readReq = 1'b1;
    step();
    readReq = 1'b0;
    checks++; if (readData !== 16'hA000) begin errors++; $display("FAIL full_head got %h want a000", readData); end
    checks++; if (inputAccept !== 1'b1) begin errors++; $display("FAIL full_reopen got %b want 1", inputAccept); end
    for (int i = 1; i < 4; i++) begin
      readReq = 1'b1;
      step();
      readReq = 1'b0;
      checks++; if (readValid !== 1'b1 || readData !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", i, readValid, readData, 16'hA000 + 16'(i));
      end
    end
  endtask

  task automatic test_read_miss;
    readReq = 1'b1;
    checks++; if (ioBusy !== 1'b1) begin errors++; $display("FAIL miss_busy_req got %b want 1", ioBusy); end
    step();
    readReq = 1'b0;
    checks++; if (inputWaiting !== 1'b1 || ioBusy !== 1'b1 || readValid !== 1'b0) begin
      errors++; $display("FAIL miss_wait got w=%b b=%b v=%b want w=1 b=1 v=0", inputWaiting, ioBusy, readValid);
    end
    for (int i = 0; i < 4; i++) step();
    checks++; if (inputWaiting !== 1'b1) begin errors++; $display("FAIL miss_still_wait got %b want 1", inputWaiting); end
    inputReady = 1'b1; parallelIn = 16'hA5A5;
    checks++; if (inputAccept !== 1'b1) begin errors++; $display("FAIL miss_accept got %b want 1", inputAccept); end
    step();
    inputReady = 1'b0;
    checks++; if (readValid !== 1'b1 || readData !== 16'hA5A5) begin
      errors++; $display("FAIL miss_data got v=%b d=%h want v=1 d=a5a5", readValid, readData);
    end
    checks++; if (ioBusy !== 1'b0 || inputWaiting !== 1'b0) begin
      errors++; $display("FAIL miss_release got b=%b w=%b want 0 0", ioBusy, inputWaiting);
    end
    // Bypassed word must not be left in the FIFO: a read still sees it empty.
    readReq = 1'b1;
    #1;
    checks++; if (ioBusy !== 1'b1) begin errors++; $display("FAIL miss_fifo_empty got %b want 1", ioBusy); end
    readReq = 1'b0;
    step();
  endtask

  task automatic test_flash;
    flashEnable = 1'b1;
    step();
    checks++; if (ioBusy !== 1'b1 || inputAccept !== 1'b1) begin
      errors++; $display("FAIL flash_enter got b=%b a=%b want 1 1", ioBusy, inputAccept);
    end
    for (int i = 1; i <= 4; i++) begin
      inputReady = 1'b1; parallelIn = 16'(i);
      step();
      checks++; if (romWe !== 1'b1 || romAddr !== 2'(i - 1) || romWd !== 16'(i)) begin
        errors++; $display("FAIL flash_wr%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i, romWe, romAddr, romWd, i - 1, 16'(i));
      end
    end
    checks++; if (flashFull !== 1'b1 || inputAccept !== 1'b0) begin
      errors++; $display("FAIL flash_full got f=%b a=%b want 1 0", flashFull, inputAccept);
    end
    parallelIn = 16'h0005;
    writeReq = 1'b1; writeData = 16'hDEAD;
    step();
    inputReady = 1'b0; writeReq = 1'b0;
    checks++; if (romWe !== 1'b0 || romAddr !== 2'd3 || romWd !== 16'h0004) begin
      errors++; $display("FAIL flash_refuse got we=%b a=%0d d=%h want we=0 a=3 d=0004", romWe, romAddr, romWd);
    end
    checks++; if (outValid !== 1'b0 || parallelOut === 16'hDEAD) begin
      errors++; $display("FAIL flash_write_ignored got v=%b o=%h want v=0 o!=dead", outValid, parallelOut);
    end
    flashEnable = 1'b0;
    step();
    checks++; if (flashDone !== 1'b1 || flashFull !== 1'b0 || ioBusy !== 1'b0) begin
      errors++; $display("FAIL flash_exit got d=%b f=%b b=%b want 1 0 0", flashDone, flashFull, ioBusy);
    end
    step();
    checks++; if (flashDone !== 1'b0) begin errors++; $display("FAIL flash_done_pulse got %b want 0", flashDone); end
  endtask

  task automatic test_simul_rw;
    inputReady = 1'b1; parallelIn = 16'h0042;
    step();
    inputReady = 1'b0;
    readReq = 1'b1; writeReq = 1'b1; writeData = 16'h7777;
    step();
    readReq = 1'b0; writeReq = 1'b0;
    checks++; if (readValid !== 1'b1 || readData !== 16'h0042) begin
      errors++; $display("FAIL rw_read got v=%b d=%h want v=1 d=0042", readValid, readData);
    end
    checks++; if (outValid !== 1'b1 || parallelOut !== 16'h7777) begin
      errors++; $display("FAIL rw_write got v=%b o=%h want v=1 o=7777", outValid, parallelOut);
    end
    step();
    checks++; if (outValid !== 1'b0 || parallelOut !== 16'h7777) begin
      errors++; $display("FAIL rw_hold got v=%b o=%h want v=0 o=7777", outValid, parallelOut);
    end
  endtask

  task automatic test_reset_mid_flash;
    flashEnable = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      inputReady = 1'b1; parallelIn = 16'h0010 * 16'(i + 1);
      step();
    end
    inputReady = 1'b0;
    checks++; if (romAddr !== 2'd1 || romWd !== 16'h0020) begin
      errors++; $display("FAIL rmf_pre got a=%0d d=%h want a=1 d=0020", romAddr, romWd);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; flashEnable = 1'b0;
    checks++; if (romAddr !== 2'd0 || romWd !== 16'h0 || inputAccept !== 1'b1 || ioBusy !== 1'b0) begin
      errors++; $display("FAIL rmf_state got a=%0d d=%h acc=%b b=%b want 0 0 1 0", romAddr, romWd, inputAccept, ioBusy);
    end
    checks++; if ({readValid, outValid, romWe, flashDone, flashFull, inputWaiting} !== 6'b0) begin
      errors++; $display("FAIL rmf_strobes got %b want 000000", {readValid, outValid, romWe, flashDone, flashFull, inputWaiting});
    end
    readReq = 1'b1;
    step();
    readReq = 1'b0;
    checks++; if (inputWaiting !== 1'b1) begin errors++; $display("FAIL rmf_wait got %b want 1", inputWaiting); end
    inputReady = 1'b1; parallelIn = 16'h0BAD;
    step();
    inputReady = 1'b0;
    checks++; if (readValid !== 1'b1 || readData !== 16'h0BAD) begin
      errors++; $display("FAIL rmf_read got v=%b d=%h want v=1 d=0bad", readValid, readData);
    end
  endtask

  initial begin
    test_reset();
    test_buffered();
    test_full();
    test_read_miss();
    test_flash();
    test_simul_rw();
    test_reset_mid_flash();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
